boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Program loader that sits directly upstream of the SPARC DataPath/ControlUnit pair.
- Accepts 32-bit instruction words over a valid/ready stream (e.g. from a file reader or UART deframer) and writes each word big-endian into the byte-addressed RAM through the RAM's MFC handshake.
- While loading, holds the ControlUnit in reset; afterwards releases it so execution starts at BASE_ADDR.

Parameters:
- ADDR_W, 9, RAM byte-address width (512-byte RAM).
- BASE_ADDR, 0, byte address of the first loaded word; must be a multiple of 4.
- RESET_CYCLES, 2, number of cycles cpu_reset stays high after the last byte write completes (≥1).
- MFC_TIMEOUT, 15, maximum cycles a byte write may wait for mem_mfc before the loader errors.

Ports:
- Clk  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- word_valid  in  1  source has a word.
- word_data  in  32  instruction word; bits [31:24] go to the lowest address.
- word_last  in  1  qualifies the final word of the program.
- word_ready  out  1  loader accepts word_data on this edge.
- mem_we  out  1  byte-write request to RAM.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte data.
- mem_mfc  in  1  RAM memory-function-complete for the current request.
- cpu_reset  out  1  active-high reset to the ControlUnit.
- load_done  out  1  program loaded and CPU released.
- load_error  out  1  sticky error (overflow or MFC timeout).
- word_count  out  ADDR_W-1  words written so far.

Behaviour:
- All outputs are registered.
- On RESET low, asynchronously: state=LOAD, word_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_reset=1, load_done=0, load_error=0, word_count=0, byte_idx=0, timeout counter=0.
- LOAD:
  - word_ready=1 (from the cycle after reset deasserts).
  - On an edge with word_valid&word_ready: latch word and last flag, word_ready→0, go to WRITE with byte_idx=0, mem_we=1, mem_addr=BASE_ADDR+4*word_count, mem_wdata=word[31:24].
  - Overflow check at acceptance: if BASE_ADDR+4*word_count+3 > 2^ADDR_W-1, do not accept. Go to ERROR instead; word_ready=0 from the next cycle.
- WRITE:
  - mem_we stays high; address and data are stable until mem_mfc is sampled high.
  - On the mfc edge with byte_idx<3: byte_idx+1, mem_addr+1, mem_wdata = next byte (order [23:16], [15:8], [7:0]). Writes are back-to-back with no idle cycle. Timeout counter clears.
  - On the mfc edge with byte_idx=3: mem_we→0 and word_count+1. Then go to RELEASE if the latched last flag is set, otherwise go to LOAD with word_ready=1.
  - The timeout counter increments on every WRITE cycle without mfc. When it reaches MFC_TIMEOUT, go to ERROR: mem_we→0.
- RELEASE:
  - cpu_reset stays 1 for exactly RESET_CYCLES cycles, counted from the edge that left WRITE.
  - Then cpu_reset→0, load_done→1, go to RUN.
- RUN:
  - Terminal state. word_ready=0, mem_we=0; input words are ignored.
  - mem_mfc is ignored in every state except WRITE.
- ERROR:
  - Terminal until RESET. load_error=1, cpu_reset=1, word_ready=0, mem_we=0.
- Latency:
  - A word with an immediate mfc response costs 1 accept cycle + 4 write cycles.
  - Best-case throughput is one word per 5 cycles.
- Reset mid-write:
  - mem_we drops asynchronously and the partially written word is abandoned.
  - cpu_reset returns to 1.
- A zero-length program is not possible: at least one word carries word_last.

Decomposition:
- Shared package boot_loader_pkg holds:
  - state encoding (LOAD, WRITE, RELEASE, RUN, ERROR; 3-bit);
  - a byte-select constant table mapping byte_idx to bit slices.
- Byte lane selection is inline. No sub-module is needed; a single counter is reused as both the RELEASE counter and the MFC timeout counter.

Test Plan:
- 3-word program, words 0x8210_2005, 0x8400_4001, 0x0100_0000 (last on word 3), mem_mfc tied high → RAM bytes 0..11 hold 82 10 20 05 84 00 40 01 01 00 00 00; word_count=3; cpu_reset falls 2 cycles after the last byte; load_done=1.
- mem_mfc delayed 3 cycles per byte → mem_addr and mem_wdata stay stable while waiting; the write sequence is unchanged and no error occurs.
- mem_mfc held low → load_error=1 after 15 WRITE cycles; mem_we=0; cpu_reset stays 1; further words are not accepted.
- ADDR_W=4 with 5 words offered → 4 words are written (16 bytes); word 5 is refused; load_error=1; word_ready=0.
- RESET driven low during byte 2 of word 1 → mem_we=0 immediately; all outputs take their reset values; a reload from word 0 succeeds.
- word_valid pulsed high during WRITE and RUN → not accepted (word_ready=0); RAM contents are unchanged.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types for the program loader: FSM encoding and big-endian byte lane table.
// Pure declarations; no latency or flow-control behaviour of its own.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  // LSB position of each byte, indexed by byte_idx; index 0 goes to the lowest address.
  localparam logic [4:0] BYTE_LSB [4] = '{5'd24, 5'd16, 5'd8, 5'd0};

endpackage

// File: rtl/boot_loader.sv
// Streams 32-bit words big-endian into byte RAM over the MFC handshake, then releases the CPU.
// 1 accept + 4 write cycles per word at best; word_ready is low while a word is being written.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int BASE_ADDR    = 0,
  parameter int RESET_CYCLES = 2,
  parameter int MFC_TIMEOUT  = 15
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_mfc,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W-2:0] word_count
);

  localparam int CNT_MAX = (MFC_TIMEOUT > RESET_CYCLES) ? MFC_TIMEOUT : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state;
  logic [1:0]         byte_idx;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        word_q;
  logic               last_q;
  logic [ADDR_W+1:0]  word_base;
  logic [ADDR_W+1:0]  word_end;
  logic               overflow;

  // Computed two bits wider so a word that would run past the top of RAM is visible.
  assign word_base = (ADDR_W+2)'(BASE_ADDR) + {1'b0, word_count, 2'b00};
  assign word_end  = word_base + (ADDR_W+2)'(3);
  assign overflow  = word_end > (ADDR_W+2)'((1 << ADDR_W) - 1);

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_LOAD;
      word_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= ADDR_W'(BASE_ADDR);
      mem_wdata  <= 8'h00;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      word_count <= '0;
      byte_idx   <= 2'd0;
      cnt        <= '0;
      word_q     <= 32'h0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (!word_ready) begin
            word_ready <= 1'b1;
          end else if (word_valid) begin
            word_ready <= 1'b0;
            if (overflow) begin
              state      <= ST_ERROR;
              load_error <= 1'b1;
            end else begin
              state     <= ST_WRITE;
              word_q    <= word_data;
              last_q    <= word_last;
              byte_idx  <= 2'd0;
              cnt       <= '0;
              mem_we    <= 1'b1;
              mem_addr  <= word_base[ADDR_W-1:0];
              mem_wdata <= word_data[31:24];
            end
          end
        end

        ST_WRITE: begin
          if (mem_mfc) begin
            cnt <= '0;
            if (byte_idx != 2'd3) begin
              byte_idx  <= byte_idx + 2'd1;
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_wdata <= word_q[BYTE_LSB[byte_idx + 2'd1] +: 8];
            end else begin
              mem_we     <= 1'b0;
              word_count <= word_count + (ADDR_W-1)'(1);
              if (last_q) begin
                state <= ST_RELEASE;
              end else begin
                state      <= ST_LOAD;
                word_ready <= 1'b1;
              end
            end
          end else if (cnt == CNT_W'(MFC_TIMEOUT - 1)) begin
            state      <= ST_ERROR;
            mem_we     <= 1'b0;
            load_error <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // cnt was cleared by the final mfc, so counting starts at the edge that left WRITE.
        ST_RELEASE: begin
          if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
            cpu_reset <= 1'b0;
            load_done <= 1'b1;
            state     <= ST_RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RUN, ST_ERROR: begin
          word_ready <= 1'b0;
          mem_we     <= 1'b0;
        end

        default: begin
          state      <= ST_ERROR;
          load_error <= 1'b1;
          mem_we     <= 1'b0;
          word_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: default 512-byte instance plus a 16-byte instance for overflow.
module tb_boot_loader;

  logic        Clk;
  logic        RESET;
  int          checks;
  int          errors;
  int          cyc;

  logic        word_valid, word_last, word_ready, mem_we, mem_mfc;
  logic        cpu_reset, load_done, load_error;
  logic [31:0] word_data;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  word_count;
  logic [7:0]  ram [512];

  logic        s_word_valid, s_word_last, s_word_ready, s_mem_we, s_mem_mfc;
  logic        s_cpu_reset, s_load_done, s_load_error;
  logic [31:0] s_word_data;
  logic [3:0]  s_mem_addr;
  logic [7:0]  s_mem_wdata;
  logic [2:0]  s_word_count;
  logic [7:0]  s_ram [16];

  int          mfc_delay;
  logic        mfc_hold_low;
  int          wait_cnt;

  boot_loader dut (
    .Clk(Clk), .RESET(RESET), .word_valid(word_valid), .word_data(word_data),
    .word_last(word_last), .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mfc(mem_mfc), .cpu_reset(cpu_reset), .load_done(load_done),
    .load_error(load_error), .word_count(word_count)
  );

  boot_loader #(.ADDR_W(4)) dut_s (
    .Clk(Clk), .RESET(RESET), .word_valid(s_word_valid), .word_data(s_word_data),
    .word_last(s_word_last), .word_ready(s_word_ready), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_mfc(s_mem_mfc), .cpu_reset(s_cpu_reset), .load_done(s_load_done),
    .load_error(s_load_error), .word_count(s_word_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // RAM model: mfc answers after mfc_delay waiting cycles per byte, or never when held low.
  assign mem_mfc   = mem_we && !mfc_hold_low && (wait_cnt >= mfc_delay);
  assign s_mem_mfc = s_mem_we;

  always @(posedge Clk or negedge RESET) begin
    if (!RESET) wait_cnt <= 0;
    else if (mem_we && !mem_mfc) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge Clk) begin
    if (mem_we && mem_mfc) ram[mem_addr] <= mem_wdata;
    if (s_mem_we && s_mem_mfc) s_ram[s_mem_addr] <= s_mem_wdata;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not end, got running exp finished");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge Clk);
    RESET = 1'b0;
    word_valid = 1'b0;
    s_word_valid = 1'b0;
    repeat (2) @(negedge Clk);
    RESET = 1'b1;
    @(negedge Clk);
  endtask

  // Offers a word from a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic last, output int t);
    bit ok;
    ok = 0;
    t = 0;
    word_data = d;
    word_last = last;
    word_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (word_ready === 1'b1) begin ok = 1; t = cyc; break; end
      @(negedge Clk);
    end
    if (ok) @(negedge Clk);
    word_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_word_accept: word %h got not accepted exp accepted", d);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (load_done === 1'b1) break;
      @(negedge Clk);
    end
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: load_done got %b exp 1", load_done);
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    #1 RESET = 1'b0;
    #1;
    checks += 9;
    if (word_ready !== 1'b0) begin errors++; $display("FAIL rst_word_ready: got %b exp 0", word_ready); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b exp 0", mem_we); end
    if (mem_addr !== 9'd0) begin errors++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
    if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); end
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %b exp 1", cpu_reset); end
    if (load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done: got %b exp 0", load_done); end
    if (load_error !== 1'b0) begin errors++; $display("FAIL rst_load_error: got %b exp 0", load_error); end
    if (word_count !== 8'd0) begin errors++; $display("FAIL rst_word_count: got %0d exp 0", word_count); end
    if (s_word_ready !== 1'b0) begin errors++; $display("FAIL rst_s_word_ready: got %b exp 0", s_word_ready); end
    repeat (2) @(negedge Clk);
    RESET = 1'b1;
    @(negedge Clk);
    checks += 2;
    if (word_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b exp 1", word_ready); end
    if (cpu_reset !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_idle_after: cpu_reset %b mem_we %b exp 1 0", cpu_reset, mem_we);
    end
  endtask

  task automatic test_load();
    logic [7:0] exp_b [12] = '{8'h82, 8'h10, 8'h20, 8'h05, 8'h84, 8'h00, 8'h40, 8'h01,
                               8'h01, 8'h00, 8'h00, 8'h00};
    int t1, t2, t3;
    do_reset();
    mfc_delay = 0;
    mfc_hold_low = 1'b0;
    send_word(32'h8210_2005, 1'b0, t1);
    send_word(32'h8400_4001, 1'b0, t2);
    send_word(32'h0100_0000, 1'b1, t3);
    checks += 2;
    if (t2 - t1 !== 5) begin errors++; $display("FAIL b2b_gap_1_2: got %0d exp 5", t2 - t1); end
    if (t3 - t2 !== 5) begin errors++; $display("FAIL b2b_gap_2_3: got %0d exp 5", t3 - t2); end
    repeat (3) @(negedge Clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 9'd11 || mem_wdata !== 8'h00) begin
      errors++; $display("FAIL load_last_byte: we %b addr %0d data %h exp 1 11 00", mem_we, mem_addr, mem_wdata);
    end
    @(negedge Clk);
    checks += 2;
    if (mem_we !== 1'b0 || word_count !== 8'd3) begin
      errors++; $display("FAIL load_end: we %b count %0d exp 0 3", mem_we, word_count);
    end
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL load_hold1: cpu_reset got %b exp 1", cpu_reset); end
    @(negedge Clk);
    checks++;
    if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin
      errors++; $display("FAIL load_hold2: cpu_reset %b load_done %b exp 1 0", cpu_reset, load_done);
    end
    @(negedge Clk);
    checks++;
    if (cpu_reset !== 1'b0 || load_done !== 1'b1 || load_error !== 1'b0) begin
      errors++; $display("FAIL load_release: cpu_reset %b done %b err %b exp 0 1 0", cpu_reset, load_done, load_error);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (ram[i] !== exp_b[i]) begin errors++; $display("FAIL load_ram[%0d]: got %h exp %h", i, ram[i], exp_b[i]); end
    end
  endtask

  task automatic test_mfc_delay();
    logic [7:0] eb [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int t;
    do_reset();
    mfc_delay = 3;
    send_word(32'hA1B2_C3D4, 1'b1, t);
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 9'(c / 4) || mem_wdata !== eb[c / 4]) begin
        errors++;
        $display("FAIL delay_stable c%0d: we %b addr %0d data %h exp 1 %0d %h", c, mem_we, mem_addr, mem_wdata, c / 4, eb[c / 4]);
      end
      @(negedge Clk);
    end
    checks++;
    if (mem_we !== 1'b0 || load_error !== 1'b0) begin
      errors++; $display("FAIL delay_end: we %b err %b exp 0 0", mem_we, load_error);
    end
    wait_done();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[i] !== eb[i]) begin errors++; $display("FAIL delay_ram[%0d]: got %h exp %h", i, ram[i], eb[i]); end
    end
    mfc_delay = 0;
  endtask

  task automatic test_timeout();
    int t;
    do_reset();
    mfc_hold_low = 1'b1;
    send_word(32'h1234_5678, 1'b0, t);
    repeat (14) @(negedge Clk);
    checks++;
    if (mem_we !== 1'b1 || load_error !== 1'b0) begin
      errors++; $display("FAIL timeout_early: we %b err %b exp 1 0", mem_we, load_error);
    end
    @(negedge Clk);
    checks++;
    if (load_error !== 1'b1 || mem_we !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL timeout_hit: err %b we %b cpu_reset %b exp 1 0 1", load_error, mem_we, cpu_reset);
    end
    word_data = 32'h5555_AAAA;
    word_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++;
      if (word_ready !== 1'b0 || mem_we !== 1'b0) begin
        errors++; $display("FAIL timeout_refuse c%0d: ready %b we %b exp 0 0", i, word_ready, mem_we);
      end
    end
    word_valid = 1'b0;
    checks++;
    if (word_count !== 8'd0 || load_error !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: count %0d err %b exp 0 1", word_count, load_error);
    end
    mfc_hold_low = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] sw [5] = '{32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF, 32'hDEAD_BEEF};
    bit ok;
    do_reset();
    s_word_last = 1'b0;
    for (int w = 0; w < 5; w++) begin
      s_word_data = sw[w];
      s_word_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        if (s_word_ready === 1'b1) begin ok = 1; break; end
        @(negedge Clk);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_ready w%0d: got 0 exp 1", w); end
      @(negedge Clk);
      s_word_valid = 1'b0;
    end
    checks += 2;
    if (s_load_error !== 1'b1 || s_word_ready !== 1'b0 || s_mem_we !== 1'b0) begin
      errors++; $display("FAIL ovf_error: err %b ready %b we %b exp 1 0 0", s_load_error, s_word_ready, s_mem_we);
    end
    if (s_word_count !== 3'd4 || s_cpu_reset !== 1'b1) begin
      errors++; $display("FAIL ovf_count: count %0d cpu_reset %b exp 4 1", s_word_count, s_cpu_reset);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (s_ram[i] !== 8'(i * 8'h11)) begin
        errors++; $display("FAIL ovf_ram[%0d]: got %h exp %h", i, s_ram[i], 8'(i * 8'h11));
      end
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (s_word_ready !== 1'b0 || s_load_error !== 1'b1) begin
      errors++; $display("FAIL ovf_terminal: ready %b err %b exp 0 1", s_word_ready, s_load_error);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] eb [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
    int t;
    do_reset();
    send_word(32'h1122_3344, 1'b0, t);
    repeat (2) @(negedge Clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 9'd2) begin
      errors++; $display("FAIL mid_pre: we %b addr %0d exp 1 2", mem_we, mem_addr);
    end
    #2 RESET = 1'b0;
    #1;
    checks += 2;
    if (mem_we !== 1'b0 || cpu_reset !== 1'b1 || word_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++; $display("FAIL mid_async: we %b cpu_reset %b ready %b done %b exp 0 1 0 0", mem_we, cpu_reset, word_ready, load_done);
    end
    if (mem_addr !== 9'd0 || mem_wdata !== 8'h00 || word_count !== 8'd0 || load_error !== 1'b0) begin
      errors++; $display("FAIL mid_values: addr %0d data %h count %0d err %b exp 0 00 0 0", mem_addr, mem_wdata, word_count, load_error);
    end
    do_reset();
    send_word(32'hDEAD_BEEF, 1'b0, t);
    send_word(32'h0BAD_F00D, 1'b1, t);
    wait_done();
    checks++;
    if (word_count !== 8'd2) begin errors++; $display("FAIL mid_reload_count: got %0d exp 2", word_count); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[i] !== eb[i]) begin errors++; $display("FAIL mid_ram[%0d]: got %h exp %h", i, ram[i], eb[i]); end
    end
  endtask

  task automatic test_ignore();
    logic [7:0] eb [5] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0B};
    int t;
    do_reset();
    send_word(32'hCAFE_F00D, 1'b1, t);
    word_data = 32'hFFFF_FFFF;
    word_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (word_ready !== 1'b0) begin errors++; $display("FAIL ign_write c%0d: ready got %b exp 0", i, word_ready); end
      @(negedge Clk);
    end
    word_valid = 1'b0;
    wait_done();
    word_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++;
      if (word_ready !== 1'b0 || mem_we !== 1'b0) begin
        errors++; $display("FAIL ign_run c%0d: ready %b we %b exp 0 0", i, word_ready, mem_we);
      end
    end
    word_valid = 1'b0;
    checks++;
    if (word_count !== 8'd1 || load_done !== 1'b1) begin
      errors++; $display("FAIL ign_count: count %0d done %b exp 1 1", word_count, load_done);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ram[i] !== eb[i]) begin errors++; $display("FAIL ign_ram[%0d]: got %h exp %h", i, ram[i], eb[i]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET = 1'b0;
    word_valid = 1'b0;
    word_data = 32'h0;
    word_last = 1'b0;
    s_word_valid = 1'b0;
    s_word_data = 32'h0;
    s_word_last = 1'b0;
    mfc_delay = 0;
    mfc_hold_low = 1'b0;
    repeat (2) @(negedge Clk);
    RESET = 1'b1;
    test_reset();
    test_load();
    test_mfc_delay();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
